// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline sequencer: opcodes, FSM states and
// source-usage decode helpers. Also used by the forwarding unit.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    localparam int CNT_W = 4;

    // JAL, HALT and unknown opcodes read no register sources.
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
        rs2_hit  = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
        // x0 is never a real dependency.
        load_use = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use, redirect and freeze control plus the HALT drain FSM.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  ext_stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  drain_active,
    output logic                  halted,
`ifdef HAZARD_STATS_EN
    output logic [15:0]           stall_count,
    output logic [15:0]           flush_count,
`endif
    output logic [1:0]            dbg_state
);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic pc_w, ifid_w, ifid_f, idex_f, drain_a;
    logic lu_bubble, redirect_taken;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_w           = 1'b0;
        ifid_w         = 1'b0;
        ifid_f         = 1'b0;
        idex_f         = 1'b0;
        drain_a        = 1'b0;
        lu_bubble      = 1'b0;
        redirect_taken = 1'b0;
        case (state_q)
            RUN: begin
                if (ext_stall) begin
                    // frozen: all enables and flushes low
                end else if (ex_redirect) begin
                    pc_w           = 1'b1;
                    ifid_w         = 1'b1;
                    ifid_f         = 1'b1;
                    idex_f         = 1'b1;
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    idex_f    = 1'b1;
                    lu_bubble = 1'b1;
                end else if (id_opcode == OP_HALT) begin
                    idex_f  = 1'b1;
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                end
            end
            DRAIN: begin
                drain_a = 1'b1;
                // A stall holds the count so the drain length counts real advances only.
                if (!ext_stall) begin
                    idex_f = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HALTED: begin
                ifid_f = 1'b1;
                idex_f = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the controls directly so the pipeline is held clean while rst_n is low.
    assign pc_write     = rst_n & pc_w;
    assign ifid_write   = rst_n & ifid_w;
    assign ifid_flush   = ~rst_n | ifid_f;
    assign idex_flush   = ~rst_n | idex_f;
    assign drain_active = rst_n & drain_a;
    assign halted       = (state_q == HALTED);
    assign dbg_state    = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (lu_bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (redirect_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DRAIN_CYCLES=4); expected control
// vectors are hand-computed per cycle.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] HLT_OP = 7'b1111111;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    // Vector order: {pc_write, ifid_write, ifid_flush, idex_flush, drain_active, halted}
    localparam logic [5:0] V_NORM  = 6'b110000;
    localparam logic [5:0] V_RST   = 6'b001100;
    localparam logic [5:0] V_LU    = 6'b000100;
    localparam logic [5:0] V_FRZ   = 6'b000000;
    localparam logic [5:0] V_REDIR = 6'b111100;
    localparam logic [5:0] V_DRAIN = 6'b000110;
    localparam logic [5:0] V_DSTL  = 6'b000010;
    localparam logic [5:0] V_HALT  = 6'b001101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] id_opcode = I_OP;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       ex_memread = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_redirect = 1'b0;
    logic       ext_stall = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, drain_active, halted;
    logic [1:0] dbg_state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (4),
        .REG_ADDR_W   (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_opcode    (id_opcode),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .ext_stall    (ext_stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .drain_active (drain_active),
        .halted       (halted),
`ifdef HAZARD_STATS_EN
        .stall_count  (stall_count),
        .flush_count  (flush_count),
`endif
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mr, input logic [4:0] rd, input logic redir,
                         input logic stl);
        id_opcode   = op;
        id_rs1      = rs1;
        id_rs2      = rs2;
        ex_memread  = mr;
        ex_rd       = rd;
        ex_redirect = redir;
        ext_stall   = stl;
    endtask

    task automatic idle();
        drive(I_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic cycle_check(input string tag, input logic [5:0] exp_v, input logic [1:0] exp_s);
        @(negedge clk);
        check(tag, {10'd0, pc_write, ifid_write, ifid_flush, idex_flush, drain_active, halted},
              {10'd0, exp_v});
        check({tag, "_st"}, {14'd0, dbg_state}, {14'd0, exp_s});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst"}, {10'd0, pc_write, ifid_write, ifid_flush, idex_flush, drain_active, halted},
              {10'd0, V_RST});
        check({tag, "_rst_st"}, {14'd0, dbg_state}, {14'd0, S_RUN});
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("reset_out", {10'd0, pc_write, ifid_write, ifid_flush, idex_flush, drain_active, halted},
              {10'd0, V_RST});
        check("reset_state", {14'd0, dbg_state}, {14'd0, S_RUN});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle_check("idle", V_NORM, S_RUN);

        // LW x5 in EX, ADD x6,x5,x7 in ID: one bubble, then normal.
        drive(R_OP, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0);
        cycle_check("lu_rs1", V_LU, S_RUN);
        drive(R_OP, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle_check("lu_after", V_NORM, S_RUN);
        drive(R_OP, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        cycle_check("lu_rs2", V_LU, S_RUN);
        drive(R_OP, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle_check("lu_x0", V_NORM, S_RUN);
        drive(SW_OP, 5'd5, 5'd6, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle_check("sw_base_no", V_NORM, S_RUN);
        drive(SW_OP, 5'd5, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle_check("sw_data_lu", V_LU, S_RUN);
        drive(I_OP, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle_check("itype_rs2_no", V_NORM, S_RUN);
        drive(JAL_OP, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle_check("jal_no", V_NORM, S_RUN);
        drive(R_OP, 5'd5, 5'd7, 1'b0, 5'd5, 1'b0, 1'b0);
        cycle_check("no_memread", V_NORM, S_RUN);

        // Freeze beats load-use and redirect.
        drive(R_OP, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b1);
        cycle_check("stall_lu", V_FRZ, S_RUN);
        drive(R_OP, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1);
        cycle_check("stall_redir", V_FRZ, S_RUN);

        // Redirect with wrong-path HALT / load-use in ID.
        drive(HLT_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle_check("redir_halt", V_REDIR, S_RUN);
        drive(R_OP, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle_check("redir_lu", V_REDIR, S_RUN);
        idle();
        cycle_check("redir_after", V_NORM, S_RUN);

        // HALT at cycle N: drain N+1..N+4, halted at N+5.
        drive(HLT_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle_check("halt_id", V_LU, S_RUN);
        cycle_check("drain1", V_DRAIN, S_DRAIN);
        ex_redirect = 1'b1;
        cycle_check("drain2_redir", V_DRAIN, S_DRAIN);
        ex_redirect = 1'b0;
        cycle_check("drain3", V_DRAIN, S_DRAIN);
        cycle_check("drain4", V_DRAIN, S_DRAIN);
        cycle_check("halted1", V_HALT, S_HALTED);
        drive(R_OP, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle_check("halted_sticky", V_HALT, S_HALTED);
        reset_pulse("from_halted");
        cycle_check("post_rst", V_NORM, S_RUN);

        // Three stall cycles mid-drain push halted out by three.
        drive(HLT_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle_check("s_halt_id", V_LU, S_RUN);
        cycle_check("s_drain1", V_DRAIN, S_DRAIN);
        for (int i = 0; i < 3; i++) begin
            ext_stall = 1'b1;
            cycle_check($sformatf("s_stall%0d", i), V_DSTL, S_DRAIN);
        end
        ext_stall = 1'b0;
        cycle_check("s_drain2", V_DRAIN, S_DRAIN);
        cycle_check("s_drain3", V_DRAIN, S_DRAIN);
        cycle_check("s_drain4", V_DRAIN, S_DRAIN);
        cycle_check("s_halted", V_HALT, S_HALTED);

        // Reset asserted mid-drain.
        reset_pulse("from_halted2");
        drive(HLT_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle_check("m_halt_id", V_LU, S_RUN);
        cycle_check("m_drain1", V_DRAIN, S_DRAIN);
        reset_pulse("mid_drain");
        cycle_check("m_post_rst", V_NORM, S_RUN);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
